// File: rtl/wts_stereo_mix_accumulator_pkg.sv
// Shared definitions for the wave-table sound blocks (mixer, envelope, tone).
// Holds the legal parameter ranges and the accumulator sizing rule, so every
// block that sums per-slot samples sizes its accumulators the same way.
package wts_stereo_mix_accumulator_pkg;

  localparam int NUM_GROUPS_MIN = 1;
  localparam int NUM_GROUPS_MAX = 8;
  localparam int SAMPLE_W_MIN   = 4;
  localparam int SAMPLE_W_MAX   = 12;
  localparam int SLOTS_MIN      = 2;
  localparam int SLOTS_MAX      = 8;
  localparam int OUT_W_MIN      = 8;
  localparam int OUT_W_MAX      = 16;

  // Wide enough for a full frame of offset-biased group sums plus sign.
  function automatic int acc_width(input int sample_w, input int num_groups,
                                   input int slots);
    return sample_w + $clog2(num_groups) + $clog2(slots) + 2;
  endfunction

endpackage

// File: rtl/wts_stereo_mix_accumulator_side.sv
// wts_mix_side: arithmetic for one stereo side.
// Sums the attenuated, routed group samples of the current slot, accumulates
// them over a frame and saturates the frame total into the output register.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   accept         cycle is not stalled
//   last           current slot is the final slot of the frame
//   sample         NUM_GROUPS signed samples, group g at [g*SAMPLE_W +: SAMPLE_W]
//   route          per-group enable for this side
//   atten          per-group 3-bit arithmetic right shift
//   sum_out        saturated frame total (held between frames)
//   clip           high for the one cycle after a latch that saturated
module wts_mix_side
  import wts_stereo_mix_accumulator_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int SAMPLE_W   = 8,
  parameter int SLOTS      = 5,
  parameter int OUT_W      = 12,
  parameter int ADD_OFFSET = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           accept,
  input  logic                           last,
  input  logic [NUM_GROUPS*SAMPLE_W-1:0] sample,
  input  logic [NUM_GROUPS-1:0]          route,
  input  logic [3*NUM_GROUPS-1:0]        atten,
  output logic [OUT_W-1:0]               sum_out,
  output logic                           clip
);

  localparam int ACC_W = acc_width(SAMPLE_W, NUM_GROUPS, SLOTS);
  localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;
  // Offset-binary bias is applied per group whether or not it is routed.
  localparam logic signed [ACC_W-1:0] OFFSET = ACC_W'(NUM_GROUPS << (SAMPLE_W - 1));

  logic signed [SAMPLE_W-1:0] smp;
  logic signed [ACC_W-1:0]    term;
  logic signed [ACC_W-1:0]    slot_sum;
  logic signed [ACC_W-1:0]    total;
  logic signed [ACC_W-1:0]    acc_p0;
  logic [OUT_W:0]             sat_res;

  // Returns {clipped, clamped value}; comparison done in a width that
  // holds both the accumulator range and the output range.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [CMP_W-1:0] w;
    logic signed [CMP_W-1:0] lo;
    logic signed [CMP_W-1:0] hi;
    logic                    c;
    w = CMP_W'(v);
    if (ADD_OFFSET != 0) begin
      lo = '0;
      hi = CMP_W'((1 << OUT_W) - 1);
    end else begin
      lo = CMP_W'(-(1 << (OUT_W - 1)));
      hi = CMP_W'((1 << (OUT_W - 1)) - 1);
    end
    c = 1'b0;
    if (w > hi) begin
      w = hi;
      c = 1'b1;
    end else if (w < lo) begin
      w = lo;
      c = 1'b1;
    end
    return {c, OUT_W'(w)};
  endfunction

  always_comb begin
    smp      = '0;
    term     = '0;
    slot_sum = (ADD_OFFSET != 0) ? OFFSET : '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      smp  = sample[g*SAMPLE_W +: SAMPLE_W];
      term = ACC_W'(smp);
      term = term >>> atten[g*3 +: 3];
      if (route[g]) slot_sum = slot_sum + term;
    end
    total   = acc_p0 + slot_sum;
    sat_res = saturate(total);
  end

  // Stage p0: frame accumulator; stage p1: latched saturated frame result.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p0  <= '0;
      sum_out <= '0;
      clip    <= 1'b0;
    end else begin
      clip <= 1'b0;
      if (accept) begin
        if (last) begin
          acc_p0  <= '0;
          sum_out <= sat_res[OUT_W-1:0];
          clip    <= sat_res[OUT_W];
        end else begin
          acc_p0 <= total;
        end
      end
    end
  end

endmodule

// File: rtl/wts_stereo_mix_accumulator.sv
// wts_stereo_mix_accumulator: stereo frame mixer for wave-table groups.
// Each accepted (hold=0) cycle is one slot; per-side slot sums are
// accumulated across SLOTS slots and the saturated totals are latched at the
// end of every frame, with a one-cycle out_valid strobe.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   hold                    stall: no register advances
//   sample                  per-group signed samples
//   enable                  routing, bit 2g+1 left / bit 2g right
//   atten                   per-group 3-bit right shift
//   slot                    current slot index
//   left_out, right_out     latched frame sums
//   out_valid               strobe for a new frame result
//   clip_l, clip_r          saturation flags, valid with out_valid
module wts_stereo_mix_accumulator
  import wts_stereo_mix_accumulator_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int SAMPLE_W   = 8,
  parameter int SLOTS      = 5,
  parameter int OUT_W      = 12,
  parameter int ADD_OFFSET = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hold,
  input  logic [NUM_GROUPS*SAMPLE_W-1:0] sample,
  input  logic [2*NUM_GROUPS-1:0]        enable,
  input  logic [3*NUM_GROUPS-1:0]        atten,
  output logic [2:0]                     slot,
  output logic [OUT_W-1:0]               left_out,
  output logic [OUT_W-1:0]               right_out,
  output logic                           out_valid,
  output logic                           clip_l,
  output logic                           clip_r
);

  logic                  accept;
  logic                  last;
  logic [NUM_GROUPS-1:0] route_l;
  logic [NUM_GROUPS-1:0] route_r;

  assign accept = ~hold;
  assign last   = (slot == 3'(SLOTS - 1));

  always_comb begin
    route_l = '0;
    route_r = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      route_l[g] = enable[2*g+1];
      route_r[g] = enable[2*g];
    end
  end

  // Stage p0: slot counter; stage p1: strobe aligned with the latched sums.
  // The strobe is recomputed every cycle so a hold cannot stretch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept & last;
      if (accept) slot <= last ? 3'd0 : slot + 3'd1;
    end
  end

  wts_mix_side #(
    .NUM_GROUPS(NUM_GROUPS), .SAMPLE_W(SAMPLE_W), .SLOTS(SLOTS),
    .OUT_W(OUT_W), .ADD_OFFSET(ADD_OFFSET)
  ) u_left (
    .clk(clk), .reset(reset), .accept(accept), .last(last),
    .sample(sample), .route(route_l), .atten(atten),
    .sum_out(left_out), .clip(clip_l)
  );

  wts_mix_side #(
    .NUM_GROUPS(NUM_GROUPS), .SAMPLE_W(SAMPLE_W), .SLOTS(SLOTS),
    .OUT_W(OUT_W), .ADD_OFFSET(ADD_OFFSET)
  ) u_right (
    .clk(clk), .reset(reset), .accept(accept), .last(last),
    .sample(sample), .route(route_r), .atten(atten),
    .sum_out(right_out), .clip(clip_r)
  );

endmodule

// File: doc/wts_stereo_mix_accumulator.md
WTS_STEREO_MIX_ACCUMULATOR -- requirements
Module: wts_stereo_mix_accumulator

Interface
REQ-001 Parameter NUM_GROUPS, default 2: wave-table groups mixed per slot; legal 1..8.
REQ-002 Parameter SAMPLE_W, default 8: signed two's-complement sample width per group; legal 4..12.
REQ-003 Parameter SLOTS, default 5: slots per frame; legal 2..8.
REQ-004 Parameter OUT_W, default 12: output sample width; legal 8..16.
REQ-005 Parameter ADD_OFFSET, default 1: 1 = unsigned offset-binary output, 0 = signed output.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 hold  input  1  CPU wave-RAM access stall; freezes the block.
REQ-009 sample  input  NUM_GROUPS*SAMPLE_W  per-group signed sample for the current slot; group g at [g*SAMPLE_W +: SAMPLE_W].
REQ-010 enable  input  2*NUM_GROUPS  per-group routing: bit 2g+1 = left, bit 2g = right.
REQ-011 atten  input  3*NUM_GROUPS  per-group arithmetic right-shift, 0..7, applied before summing.
REQ-012 slot  output  3  current slot index, 0..SLOTS-1.
REQ-013 left_out, right_out  output  OUT_W each  latched frame sums.
REQ-014 out_valid  output  1  one-cycle strobe marking new left_out/right_out.
REQ-015 clip_l, clip_r  output  1 each  set with out_valid when the corresponding side saturated.

Function
REQ-016 A cycle with hold=0 is "accepted"; a cycle with hold=1 changes no register.
REQ-017 slot increments on each accepted cycle and wraps from SLOTS-1 to 0.
REQ-018 Per group, term = (sample >>> atten), sign-extended; left term is zero unless enable[2g+1]; right term is zero unless enable[2g].
REQ-019 slot_sum per side = sum of all group terms, plus NUM_GROUPS*2^(SAMPLE_W-1) when ADD_OFFSET=1; the offset is added regardless of enable.
REQ-020 Internal accumulators are signed, SAMPLE_W+clog2(NUM_GROUPS)+clog2(SLOTS)+2 bits wide, and never overflow internally.
REQ-021 On an accepted cycle with slot != SLOTS-1: acc <= acc + slot_sum.
REQ-022 On an accepted cycle with slot == SLOTS-1: total = acc + slot_sum; total is saturated into the output register; acc <= 0; out_valid <= 1 on the next cycle.
REQ-023 Saturation with ADD_OFFSET=1: clamp to 0..2^OUT_W-1.
REQ-024 Saturation with ADD_OFFSET=0: clamp to -2^(OUT_W-1)..2^(OUT_W-1)-1.
REQ-025 clip_l/clip_r are 1 exactly when the respective clamp altered the value; they are valid only with out_valid and are 0 otherwise.
REQ-026 out_valid is 0 in every cycle except the one following a frame latch; hold does not stretch it.
REQ-027 left_out/right_out hold their value between latches, including during hold.
REQ-028 Latency: a sample accepted in a slot appears in left_out/right_out one cycle after that frame's SLOTS-1 slot is accepted.
REQ-029 Changes to enable or atten take effect on the next accepted cycle; no partial-frame correction is applied.

Reset
REQ-030 When reset=1 at a clock edge: slot=0, accumulators=0, left_out=0, right_out=0, out_valid=0, clip_l=0, clip_r=0.
REQ-031 reset has priority over hold; mid-frame reset discards the partial frame, and the next frame starts at slot 0.

Structure
REQ-032 A shared package holds the parameter range limits and the accumulator-width function, for reuse by the envelope and tone blocks.
REQ-033 Per-side arithmetic is implemented as one sub-module, wts_mix_side (term summing, accumulation, saturation, clip flag), instantiated for left and right; the slot counter and strobe live in the top.

Verification
REQ-034 Defaults, all samples 0, enable all 1, atten 0 -> every 5 accepted cycles out_valid pulses with left_out = right_out = 1280, clip = 0.
REQ-035 Defaults, both samples 127 -> 2550 on both sides; same stimulus with OUT_W=10 -> 1023 on both sides, clip_l = clip_r = 1.
REQ-036 ADD_OFFSET=0, OUT_W=10, both samples -128 -> -512 on both sides, clips set; both samples 10 -> 100 on both sides, no clip.
REQ-037 ADD_OFFSET=0, group0 sample 64, atten 2, enable 2'b10, group1 sample 0 -> left_out = 80, right_out = 0.
REQ-038 hold asserted for 3 cycles mid-frame -> slot, outputs and the result are unchanged vs. the unheld run; out_valid arrives 3 cycles later.
REQ-039 reset pulsed at slot 2 -> all outputs 0 next cycle; the first subsequent out_valid follows 5 accepted cycles and carries a full-frame sum.
